// File: rtl/ps2_pkg.sv
// Shared types, scan-code constants and the scan-code to ASCII map for the PS/2 receiver.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

  localparam logic [7:0] CODE_E0     = 8'hE0;
  localparam logic [7:0] CODE_F0     = 8'hF0;
  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_CTRL   = 8'h14;
  localparam logic [7:0] CODE_ALT    = 8'h11;
  localparam logic [7:0] CODE_ENTER  = 8'h5A;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
    logic [7:0] ascii;
  } ps2_evt_t;

  // Set-2 scan code to ASCII. Extended codes map to 00 except keypad enter.
  function automatic logic [7:0] ps2_ascii(input logic [7:0] code, input logic ext,
                                           input logic shift);
    logic [7:0] res;
    res = 8'h00;
    if (ext) begin
      res = (code == CODE_ENTER) ? 8'h0D : 8'h00;
    end else begin
      case (code)
        8'h1C: res = 8'h61;  8'h32: res = 8'h62;  8'h21: res = 8'h63;  8'h23: res = 8'h64;
        8'h24: res = 8'h65;  8'h2B: res = 8'h66;  8'h34: res = 8'h67;  8'h33: res = 8'h68;
        8'h43: res = 8'h69;  8'h3B: res = 8'h6A;  8'h42: res = 8'h6B;  8'h4B: res = 8'h6C;
        8'h3A: res = 8'h6D;  8'h31: res = 8'h6E;  8'h44: res = 8'h6F;  8'h4D: res = 8'h70;
        8'h15: res = 8'h71;  8'h2D: res = 8'h72;  8'h1B: res = 8'h73;  8'h2C: res = 8'h74;
        8'h3C: res = 8'h75;  8'h2A: res = 8'h76;  8'h1D: res = 8'h77;  8'h22: res = 8'h78;
        8'h35: res = 8'h79;  8'h1A: res = 8'h7A;
        8'h45: res = shift ? 8'h29 : 8'h30;
        8'h16: res = shift ? 8'h21 : 8'h31;
        8'h1E: res = shift ? 8'h40 : 8'h32;
        8'h26: res = shift ? 8'h23 : 8'h33;
        8'h25: res = shift ? 8'h24 : 8'h34;
        8'h2E: res = shift ? 8'h25 : 8'h35;
        8'h36: res = shift ? 8'h5E : 8'h36;
        8'h3D: res = shift ? 8'h26 : 8'h37;
        8'h3E: res = shift ? 8'h2A : 8'h38;
        8'h46: res = shift ? 8'h28 : 8'h39;
        8'h29: res = 8'h20;
        8'h66: res = 8'h08;
        CODE_ENTER: res = 8'h0D;
        default: res = 8'h00;
      endcase
      // Letters become upper case under shift.
      if (shift && res >= 8'h61 && res <= 8'h7A) res = res - 8'h20;
    end
    return res;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchroniser, glitch filter, 11-bit frame FSM with parity/stop check and timeout.
// Latency: byte_vld_o pulses the cycle after the filtered clock falls on the stop bit.
// Backpressure: none; every good byte is a single-cycle pulse and must be consumed immediately.
// Ports: clk_i/rst_ni clock and async active-low reset; ps2_clk_i/ps2_dat_i raw async lines;
//        byte_vld_o/byte_o received byte; err_parity_o/err_timeout_o single-cycle error pulses.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       byte_vld_o,
  output logic [7:0] byte_o,
  output logic       err_parity_o,
  output logic       err_timeout_o
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic [FW-1:0] fclk_cnt_q, fdat_cnt_q;
  logic          fclk_q, fdat_q, fclk_prev_q;
  logic          strobe;

  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_q, par_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          byte_vld_q, byte_vld_d, err_par_q, err_par_d, err_to_q, err_to_d;

  // A filtered line only flips after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q  <= 2'b11;
      dat_sync_q  <= 2'b11;
      fclk_q      <= 1'b1;
      fdat_q      <= 1'b1;
      fclk_prev_q <= 1'b1;
      fclk_cnt_q  <= '0;
      fdat_cnt_q  <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q  <= {dat_sync_q[0], ps2_dat_i};
      fclk_prev_q <= fclk_q;
      if (clk_sync_q[1] == fclk_q) begin
        fclk_cnt_q <= '0;
      end else if (fclk_cnt_q == FW'(FILTER_LEN - 1)) begin
        fclk_q     <= clk_sync_q[1];
        fclk_cnt_q <= '0;
      end else begin
        fclk_cnt_q <= fclk_cnt_q + FW'(1);
      end
      if (dat_sync_q[1] == fdat_q) begin
        fdat_cnt_q <= '0;
      end else if (fdat_cnt_q == FW'(FILTER_LEN - 1)) begin
        fdat_q     <= dat_sync_q[1];
        fdat_cnt_q <= '0;
      end else begin
        fdat_cnt_q <= fdat_cnt_q + FW'(1);
      end
    end
  end

  assign strobe = fclk_prev_q & ~fclk_q;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sh_d       = sh_q;
    par_d      = par_q;
    byte_vld_d = 1'b0;
    err_par_d  = 1'b0;
    err_to_d   = 1'b0;
    tcnt_d     = (state_q == IDLE || strobe) ? '0 : tcnt_q + TW'(1);
    case (state_q)
      IDLE: if (strobe && !fdat_q) begin
        state_d   = DATA;
        bit_cnt_d = 3'd0;
      end
      DATA: if (strobe) begin
        sh_d      = {fdat_q, sh_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (strobe) begin
        par_d   = fdat_q;
        state_d = STOP;
      end
      STOP: if (strobe) begin
        if (fdat_q && (^{sh_q, par_q})) byte_vld_d = 1'b1;
        else                            err_par_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && !strobe && tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d  = IDLE;
      err_to_d = 1'b1;
      tcnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      sh_q       <= 8'h00;
      par_q      <= 1'b0;
      tcnt_q     <= '0;
      byte_vld_q <= 1'b0;
      err_par_q  <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      par_q      <= par_d;
      tcnt_q     <= tcnt_d;
      byte_vld_q <= byte_vld_d;
      err_par_q  <= err_par_d;
      err_to_q   <= err_to_d;
    end
  end

  // The shift register holds still from the stop bit until the next frame's data bits.
  assign byte_o        = sh_q;
  assign byte_vld_o    = byte_vld_q;
  assign err_parity_o  = err_par_q;
  assign err_timeout_o = err_to_q;

endmodule

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: prefix/modifier decode, ASCII mapping and a first-word-fall-through event FIFO.
// Latency: event on evt_valid 2 cycles after the stop-bit strobe when the FIFO is empty.
// Backpressure: evt_valid/evt_ready; head held stable while stalled; writes to a full FIFO are dropped (overflow).
// Ports: clk25/rst_n; ps2_clk/ps2_dat raw lines; evt_* event handshake and fields; mod_* modifier state;
//        err_parity/err_timeout pulses; overflow sticky drop flag.
// Optional: define PS2_TYPEMATIC_FILTER_EN to suppress auto-repeat makes of the held key.
module ps2_key_event_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk25,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_brk,
  output logic [7:0] evt_ascii,
  output logic       mod_shift,
  output logic       mod_ctrl,
  output logic       mod_alt,
  output logic       err_parity,
  output logic       err_timeout,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic       rx_vld, rx_timeout;
  logic [7:0] rx_byte;

  ps2_frame_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) u_frame (
    .clk_i        (clk25),
    .rst_ni       (rst_n),
    .ps2_clk_i    (ps2_clk),
    .ps2_dat_i    (ps2_dat),
    .byte_vld_o   (rx_vld),
    .byte_o       (rx_byte),
    .err_parity_o (err_parity),
    .err_timeout_o(rx_timeout)
  );
  assign err_timeout = rx_timeout;

  logic     ext_q, ext_d, brk_q, brk_d;
  logic     lsh_q, lsh_d, rsh_q, rsh_d, ctrl_q, ctrl_d, alt_q, alt_d;
  logic     evt_we;
  ps2_evt_t evt_wdat;
`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [8:0] last_q, last_d;
  logic       last_vld_q, last_vld_d;
`endif

  always_comb begin
    ext_d          = ext_q;
    brk_d          = brk_q;
    lsh_d          = lsh_q;
    rsh_d          = rsh_q;
    ctrl_d         = ctrl_q;
    alt_d          = alt_q;
    evt_we         = 1'b0;
    evt_wdat.ext   = ext_q;
    evt_wdat.brk   = brk_q;
    evt_wdat.code  = rx_byte;
    // ASCII uses the modifier state before this event is applied.
    evt_wdat.ascii = ps2_ascii(rx_byte, ext_q, lsh_q | rsh_q);
`ifdef PS2_TYPEMATIC_FILTER_EN
    last_d         = last_q;
    last_vld_d     = last_vld_q;
`endif
    if (rx_timeout) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_vld) begin
      case (rx_byte)
        CODE_E0: ext_d = 1'b1;
        CODE_F0: brk_d = 1'b1;
        8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: begin
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
        default: begin
          ext_d  = 1'b0;
          brk_d  = 1'b0;
          evt_we = 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
          if (!brk_q) begin
            if (last_vld_q && last_q == {ext_q, rx_byte}) evt_we = 1'b0;
            last_d     = {ext_q, rx_byte};
            last_vld_d = 1'b1;
          end else if (last_q == {ext_q, rx_byte}) begin
            last_vld_d = 1'b0;
          end
`endif
          if (rx_byte == CODE_LSHIFT && !ext_q) lsh_d  = !brk_q;
          if (rx_byte == CODE_RSHIFT && !ext_q) rsh_d  = !brk_q;
          if (rx_byte == CODE_CTRL)             ctrl_d = !brk_q;
          if (rx_byte == CODE_ALT)              alt_d  = !brk_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      lsh_q  <= 1'b0;
      rsh_q  <= 1'b0;
      ctrl_q <= 1'b0;
      alt_q  <= 1'b0;
    end else begin
      ext_q  <= ext_d;
      brk_q  <= brk_d;
      lsh_q  <= lsh_d;
      rsh_q  <= rsh_d;
      ctrl_q <= ctrl_d;
      alt_q  <= alt_d;
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= 9'h000;
      last_vld_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
    end
  end
`endif

  assign mod_shift = lsh_q | rsh_q;
  assign mod_ctrl  = ctrl_q;
  assign mod_alt   = alt_q;

  // Event FIFO, first-word-fall-through.
  ps2_evt_t      mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          full, rd, wr_ok, overflow_q;
  ps2_evt_t      head;

  assign evt_valid = (cnt_q != '0);
  assign full      = (cnt_q == CW'(FIFO_DEPTH));
  assign rd        = evt_valid & evt_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_ok     = evt_we & (~full | rd);

  always_ff @(posedge clk25) begin
    if (wr_ok) mem_q[wr_ptr_q] <= evt_wdat;
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd)    rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_ok, rd})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (evt_we && !wr_ok) overflow_q <= 1'b1;
    end
  end

  // Mask the uninitialised storage so outputs read zero while empty.
  assign head      = evt_valid ? mem_q[rd_ptr_q] : '0;
  assign evt_ext   = head.ext;
  assign evt_brk   = head.brk;
  assign evt_code  = head.code;
  assign evt_ascii = head.ascii;
  assign overflow  = overflow_q;

endmodule
